debug_dump_unit: RTL

Debug read-out engine that walks the integer register file or the data memory word by word and streams the contents as bytes to a host-side byte transmitter. It is the read-back counterpart of the debug load path that writes instruction memory and registers before a run. It sits outside the pipeline next to the debug/UART logic. It only reads storage while the core is halted.

---
 rtl/debug_dump_unit.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/debug_dump_unit.sv
// debug_dump_unit: streams the register file or data memory out as little-endian bytes.
// Optional macro DEBUG_DUMP_HEADER_EN prepends a two-byte header (0xA5, source select).
// Latency: 6 cycles per word with ready held high. A byte holds until valid&ready.
module debug_dump_unit #(
  parameter int NB_DATA         = 32,
  parameter int DMEM_ADDR_WIDTH = 5,
  parameter int REGFILE_DEPTH   = 32
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_sel,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [4:0]                 o_reg_raddr,
  input  logic [NB_DATA-1:0]         i_reg_rdata,
  output logic [DMEM_ADDR_WIDTH-1:0] o_dmem_raddr,
  output logic                       o_dmem_ren,
  input  logic [NB_DATA-1:0]         i_dmem_rdata,
  output logic [7:0]                 o_tx_data,
  output logic                       o_tx_valid,
  input  logic                       i_tx_ready
);

  localparam int NBYTES     = NB_DATA / 8;
  localparam int DMEM_WORDS = (2 ** DMEM_ADDR_WIDTH) / NBYTES;
  localparam int MAX_WORDS  = (REGFILE_DEPTH > DMEM_WORDS) ? REGFILE_DEPTH : DMEM_WORDS;
  // Word index is wide enough for the last word of either source, so it never wraps.
  localparam int WIDX_W     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int BIDX_W     = (NBYTES > 2) ? $clog2(NBYTES) : 1;

  localparam logic [WIDX_W-1:0] REG_LAST  = WIDX_W'(REGFILE_DEPTH - 1);
  localparam logic [WIDX_W-1:0] DMEM_LAST = WIDX_W'(DMEM_WORDS - 1);
  localparam logic [BIDX_W-1:0] BYTE_LAST = BIDX_W'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef DEBUG_DUMP_HEADER_EN
    S_HDR,
`endif
    S_REQ,
    S_LOAD,
    S_SEND,
    S_DONE
  } state_t;

  state_t                     state_q, state_d;
  logic                       sel_q, sel_d;
  logic [WIDX_W-1:0]          widx_q, widx_d;
  logic [BIDX_W-1:0]          bidx_q, bidx_d;
  logic [NB_DATA-1:0]         word_q, word_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       ren_q, ren_d;
  logic                       tx_valid_q, tx_valid_d;
  logic [7:0]                 tx_data_q, tx_data_d;
  logic [4:0]                 reg_raddr_q, reg_raddr_d;
  logic [DMEM_ADDR_WIDTH-1:0] dmem_raddr_q, dmem_raddr_d;
  logic [WIDX_W-1:0]          last_idx;
  logic                       tx_hs;

  // Next-state logic, plus output values derived from the next state so outputs are registered.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    widx_d   = widx_q;
    bidx_d   = bidx_q;
    word_d   = word_q;
    last_idx = sel_q ? DMEM_LAST : REG_LAST;
    tx_hs    = tx_valid_q && i_tx_ready;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          sel_d  = i_sel;
          widx_d = '0;
          bidx_d = '0;
`ifdef DEBUG_DUMP_HEADER_EN
          state_d = S_HDR;
`else
          state_d = S_REQ;
`endif
        end
      end
`ifdef DEBUG_DUMP_HEADER_EN
      S_HDR: begin
        if (tx_hs) begin
          if (bidx_q == BIDX_W'(1)) begin
            bidx_d  = '0;
            state_d = S_REQ;
          end else begin
            bidx_d = bidx_q + 1'b1;
          end
        end
      end
`endif
      S_REQ: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        word_d  = sel_q ? i_dmem_rdata : i_reg_rdata;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (tx_hs) begin
          if (bidx_q == BYTE_LAST) begin
            bidx_d = '0;
            if (widx_q == last_idx) begin
              state_d = S_DONE;
            end else begin
              widx_d  = widx_q + 1'b1;
              state_d = S_REQ;
            end
          end else begin
            bidx_d = bidx_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d       = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d       = (state_d == S_DONE);
    ren_d        = (state_d == S_REQ) && sel_d;
    reg_raddr_d  = 5'(widx_d);
    dmem_raddr_d = DMEM_ADDR_WIDTH'(widx_d * NBYTES);
    tx_valid_d   = 1'b0;
    tx_data_d    = 8'h00;
    if (state_d == S_SEND) begin
      tx_valid_d = 1'b1;
      tx_data_d  = 8'(word_d >> (8 * bidx_d));
    end
`ifdef DEBUG_DUMP_HEADER_EN
    if (state_d == S_HDR) begin
      tx_valid_d = 1'b1;
      tx_data_d  = (bidx_d == '0) ? 8'hA5 : {7'b0, sel_d};
    end
`endif
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      sel_q        <= 1'b0;
      widx_q       <= '0;
      bidx_q       <= '0;
      word_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ren_q        <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      reg_raddr_q  <= '0;
      dmem_raddr_q <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      widx_q       <= widx_d;
      bidx_q       <= bidx_d;
      word_q       <= word_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ren_q        <= ren_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      reg_raddr_q  <= reg_raddr_d;
      dmem_raddr_q <= dmem_raddr_d;
    end
  end

  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_dmem_ren   = ren_q;
  assign o_tx_valid   = tx_valid_q;
  assign o_tx_data    = tx_data_q;
  assign o_reg_raddr  = reg_raddr_q;
  assign o_dmem_raddr = dmem_raddr_q;

endmodule
